// File: rtl/decoder_nor_gate.sv
// Registered bit-parallel 2-input NOR built from per-lane 2:4 one-hot decoders.
// Each lane decodes {a[i], b[i]} (a is MSB) onto four lines; the NOR result is
// line 0 of that lane. The decoder lines are exported so downstream blocks can
// derive the other two-input gates from the same registered lines.
module decoder_nor_gate #(
    parameter int unsigned WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 in_valid,
    output logic [WIDTH-1:0]     nor_out,
    output logic [4*WIDTH-1:0]   dec_out,
    output logic                 out_valid
);

    localparam int unsigned DEC_W  = 4 * WIDTH;
    localparam int unsigned LANE_W = 4;

    logic [DEC_W-1:0] dec_c;
    logic [WIDTH-1:0] nor_c;

    logic [WIDTH-1:0] nor_d,   nor_q;
    logic [DEC_W-1:0] dec_d,   dec_q;
    logic             valid_d, valid_q;

    // Per-lane 2:4 decode; NOR is taken straight from line 0 of each lane.
    always_comb begin
        dec_c = '0;
        nor_c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            unique case ({a[i], b[i]})
                2'b00:   dec_c[LANE_W*i +: LANE_W] = 4'b0001;
                2'b01:   dec_c[LANE_W*i +: LANE_W] = 4'b0010;
                2'b10:   dec_c[LANE_W*i +: LANE_W] = 4'b0100;
                default: dec_c[LANE_W*i +: LANE_W] = 4'b1000;
            endcase
            nor_c[i] = dec_c[LANE_W*i];
        end
    end

    // Capture on in_valid, otherwise hold data; the valid flag is a one-cycle strobe.
    always_comb begin
        nor_d   = nor_q;
        dec_d   = dec_q;
        valid_d = 1'b0;
        if (in_valid) begin
            nor_d   = nor_c;
            dec_d   = dec_c;
            valid_d = 1'b1;
        end
    end

    // Output registers; reset clears every decoder line (deliberately not one-hot).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nor_q   <= '0;
            dec_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            nor_q   <= nor_d;
            dec_q   <= dec_d;
            valid_q <= valid_d;
        end
    end

    assign nor_out   = nor_q;
    assign dec_out   = dec_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_decoder_nor_gate.sv
// Bench for decoder_nor_gate: a 4-lane and a 1-lane instance share clock, reset
// and in_valid; expected results are queued at drive time and popped after the edge.
module tb_decoder_nor_gate;

    typedef struct packed {
        logic [3:0]  nor4;
        logic [15:0] dec4;
        logic        nor1;
        logic [3:0]  dec1;
        logic        vld;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  a4, b4;
    logic [0:0]  a1, b1;
    logic [3:0]  nor4;
    logic [15:0] dec4;
    logic        vld4;
    logic [0:0]  nor1;
    logic [3:0]  dec1;
    logic        vld1;

    int unsigned total;
    int unsigned passed;

    exp_t q[$];
    exp_t held;
    logic captured;

    decoder_nor_gate #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a4),
        .b         (b4),
        .in_valid  (in_valid),
        .nor_out   (nor4),
        .dec_out   (dec4),
        .out_valid (vld4)
    );

    decoder_nor_gate #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a1),
        .b         (b1),
        .in_valid  (in_valid),
        .nor_out   (nor1),
        .dec_out   (dec1),
        .out_valid (vld1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: NOR from the boolean form, decoder lines as a shifted one.
    function automatic logic [15:0] dec_model4(input logic [3:0] av, input logic [3:0] bv);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(4'b0001 << {av[i], bv[i]});
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic inv_ok(input logic [15:0] d, input logic [3:0] n, input int lanes);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < lanes; i++) begin
            if ($countones(d[4*i +: 4]) != 1) ok = 1'b0;
            if (n[i] !== d[4*i]) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_nor4"}, 32'(nor4), 32'h0);
        chk({tag, "_dec4"}, 32'(dec4), 32'h0);
        chk({tag, "_vld4"}, 32'(vld4), 32'h0);
        chk({tag, "_nor1"}, 32'(nor1), 32'h0);
        chk({tag, "_dec1"}, 32'(dec1), 32'h0);
        chk({tag, "_vld1"}, 32'(vld1), 32'h0);
    endtask

    // One clock: drive at negedge, queue the expectation, compare 1 time unit after posedge.
    task automatic step(input string tag, input logic [3:0] av4, input logic [3:0] bv4,
                        input logic av1, input logic bv1, input logic v);
        exp_t e;
        @(negedge clk);
        a4 = av4; b4 = bv4; a1 = av1; b1 = bv1; in_valid = v;
        if (v) begin
            held.nor4 = ~(av4 | bv4);
            held.dec4 = dec_model4(av4, bv4);
            held.nor1 = ~(av1 | bv1);
            held.dec1 = 4'(4'b0001 << {av1, bv1});
            captured  = 1'b1;
        end
        held.vld = v;
        q.push_back(held);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = q.pop_front();
            chk({tag, "_nor4"}, 32'(nor4), 32'(e.nor4));
            chk({tag, "_dec4"}, 32'(dec4), 32'(e.dec4));
            chk({tag, "_vld4"}, 32'(vld4), 32'(e.vld));
            chk({tag, "_nor1"}, 32'(nor1), 32'(e.nor1));
            chk({tag, "_dec1"}, 32'(dec1), 32'(e.dec1));
            chk({tag, "_vld1"}, 32'(vld1), 32'(e.vld));
            if (captured) begin
                chk({tag, "_inv4"}, 32'(inv_ok(dec4, nor4, 4)), 32'd1);
                chk({tag, "_inv1"}, 32'(inv_ok({12'h0, dec1}, {3'b0, nor1}, 1)), 32'd1);
            end
        end
    endtask

    task automatic clear_model();
        q.delete();
        held     = '0;
        captured = 1'b0;
    endtask

    initial begin
        total = 0;
        passed = 0;
        clear_model();
        rst_n = 1'b1; in_valid = 1'b0;
        a4 = '0; b4 = '0; a1 = '0; b1 = '0;

        // Reset asserted away from any clock edge clears outputs at once.
        #1 rst_n = 1'b0;
        #1 chk_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle cycle after release: nothing captured, outputs remain cleared.
        step("idle", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Truth table on the single lane, varied patterns on the wide lanes.
        step("tt00", 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        step("tt01", 4'h5, 4'hA, 1'b0, 1'b1, 1'b1);
        step("tt10", 4'hF, 4'h0, 1'b1, 1'b0, 1'b1);
        step("tt11", 4'hF, 4'hF, 1'b1, 1'b1, 1'b1);

        // Hold: capture 00 then present 11 without in_valid.
        step("hold_cap", 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        step("hold",     4'hF, 4'hF, 1'b1, 1'b1, 1'b0);
        chk("hold_nor1_const", 32'(nor1), 32'd1);
        chk("hold_dec1_const", 32'(dec1), 32'h1);

        // Multi-lane pattern with a fixed known answer.
        step("ml", 4'b0011, 4'b0101, 1'b0, 1'b0, 1'b1);
        chk("ml_nor4_const", 32'(nor4), 32'h8);
        chk("ml_dec4_const", 32'(dec4), 32'h1248);

        // Back-to-back random traffic.
        for (int n = 0; n < 24; n++) begin
            step("rand", 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        end

        // Reset in the middle of a cycle during valid traffic.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("midrst");
        clear_model();
        @(negedge clk);
        in_valid = 1'b1; a4 = 4'h0; b4 = 4'h0; a1 = 1'b0; b1 = 1'b0;
        @(posedge clk);
        #1 chk_zero("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;

        step("post_idle", 4'h9, 4'h3, 1'b1, 1'b0, 1'b0);
        step("post_cap",  4'h9, 4'h3, 1'b1, 1'b0, 1'b1);
        step("post_hold", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
